tree_vote_scheduler: RTL and testbench

- Sequences one shared bank of combinational per-class decision trees (classN_treeM, 51-bit feature input, 1-bit vote) across a whole ensemble.
- Accepts a feature vector over valid/ready and holds it stable on the bank input.
- Walks every (class, tree) pair one per cycle, accumulates votes per class, and returns the winning class and its vote count over valid/ready.
- Sits between the feature-capture front end and the result/reporting logic.

---
 rtl/tree_vote_scheduler.sv | 124 ++++++++++++
 tb/tb_tree_vote_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_vote_scheduler.sv
// Time-multiplexes one shared bank of per-class decision trees across the ensemble.
// It accumulates the votes for each class and returns the winning class and its score.
module tree_vote_scheduler #(
    parameter  int N_FEAT  = 51,
    parameter  int N_CLASS = 6,
    parameter  int N_TREE  = 4,
    localparam int CLS_W   = (N_CLASS > 1) ? $clog2(N_CLASS) : 1,
    localparam int TREE_W  = (N_TREE > 1) ? $clog2(N_TREE) : 1,
    localparam int SC_W    = $clog2(N_TREE + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_FEAT-1:0] in_feat,
    output logic [N_FEAT-1:0] tree_feat,
    output logic [CLS_W-1:0]  tree_class_sel,
    output logic [TREE_W-1:0] tree_idx_sel,
    input  logic              tree_vote,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CLS_W-1:0]  out_class,
    output logic [SC_W-1:0]   out_score,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EVAL, RESULT} state_t;

    localparam logic [CLS_W-1:0]  LAST_CLASS = CLS_W'(N_CLASS - 1);
    localparam logic [TREE_W-1:0] LAST_TREE  = TREE_W'(N_TREE - 1);

    state_t            state, state_nxt;
    logic [N_FEAT-1:0] feat_nxt;
    logic [CLS_W-1:0]  cls_nxt, best_class, best_class_nxt, out_class_nxt, upd_class;
    logic [TREE_W-1:0] idx_nxt;
    logic [SC_W-1:0]   acc, acc_nxt, sum, best_score, best_score_nxt, out_score_nxt, upd_score;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == RESULT);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            tree_feat      <= '0;
            tree_class_sel <= '0;
            tree_idx_sel   <= '0;
            acc            <= '0;
            best_score     <= '0;
            best_class     <= '0;
            out_class      <= '0;
            out_score      <= '0;
        end else begin
            state          <= state_nxt;
            tree_feat      <= feat_nxt;
            tree_class_sel <= cls_nxt;
            tree_idx_sel   <= idx_nxt;
            acc            <= acc_nxt;
            best_score     <= best_score_nxt;
            best_class     <= best_class_nxt;
            out_class      <= out_class_nxt;
            out_score      <= out_score_nxt;
        end
    end

    // Strict greater-than on class completion keeps the lowest class index on ties.
    always_comb begin
        state_nxt      = state;
        feat_nxt       = tree_feat;
        cls_nxt        = tree_class_sel;
        idx_nxt        = tree_idx_sel;
        acc_nxt        = acc;
        best_score_nxt = best_score;
        best_class_nxt = best_class;
        out_class_nxt  = out_class;
        out_score_nxt  = out_score;
        sum            = acc + SC_W'(tree_vote);
        upd_score      = best_score;
        upd_class      = best_class;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    feat_nxt       = in_feat;
                    cls_nxt        = '0;
                    idx_nxt        = '0;
                    acc_nxt        = '0;
                    best_score_nxt = '0;
                    best_class_nxt = '0;
                    state_nxt      = EVAL;
                end
            end
            EVAL: begin
                if (tree_idx_sel != LAST_TREE) begin
                    acc_nxt = sum;
                    idx_nxt = tree_idx_sel + TREE_W'(1);
                end else begin
                    if (sum > best_score) begin
                        upd_score = sum;
                        upd_class = tree_class_sel;
                    end
                    best_score_nxt = upd_score;
                    best_class_nxt = upd_class;
                    acc_nxt        = '0;
                    idx_nxt        = '0;
                    if (tree_class_sel == LAST_CLASS) begin
                        out_class_nxt = upd_class;
                        out_score_nxt = upd_score;
                        state_nxt     = RESULT;
                    end else begin
                        cls_nxt = tree_class_sel + CLS_W'(1);
                    end
                end
            end
            RESULT: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tree_vote_scheduler.sv
// Directed bench for tree_vote_scheduler with a scoreboard of expected winners.
// The tree bank is modelled by the low N_CLASS*N_TREE feature bits, one vote bit per (class, tree).
module tb_tree_vote_scheduler;

    localparam int N_FEAT  = 51;
    localparam int N_CLASS = 6;
    localparam int N_TREE  = 4;
    localparam int CLS_W   = 3;
    localparam int TREE_W  = 2;
    localparam int SC_W    = 3;
    localparam int N_EVAL  = N_CLASS * N_TREE;

    typedef struct packed {
        logic [CLS_W-1:0] cls;
        logic [SC_W-1:0]  score;
    } result_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [N_FEAT-1:0] in_feat;
    logic [N_FEAT-1:0] tree_feat;
    logic [CLS_W-1:0]  tree_class_sel;
    logic [TREE_W-1:0] tree_idx_sel;
    logic              tree_vote;
    logic              out_valid;
    logic              out_ready;
    logic [CLS_W-1:0]  out_class;
    logic [SC_W-1:0]   out_score;
    logic              busy;

    int      checks = 0;
    int      errors = 0;
    result_t exp_q[$];

    always #5 clk = ~clk;

    tree_vote_scheduler #(.N_FEAT(N_FEAT), .N_CLASS(N_CLASS), .N_TREE(N_TREE)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_feat        (in_feat),
        .tree_feat      (tree_feat),
        .tree_class_sel (tree_class_sel),
        .tree_idx_sel   (tree_idx_sel),
        .tree_vote      (tree_vote),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_class      (out_class),
        .out_score      (out_score),
        .busy           (busy)
    );

    function automatic logic bank_vote(input logic [N_FEAT-1:0] f,
                                       input logic [CLS_W-1:0] c,
                                       input logic [TREE_W-1:0] t);
        int k;
        if (int'(c) >= N_CLASS) return 1'b0;
        k = int'(c) * N_TREE + int'(t);
        return f[k];
    endfunction

    assign tree_vote = bank_vote(tree_feat, tree_class_sel, tree_idx_sel);

    // Reference: find the top count first, then the lowest class holding it.
    function automatic result_t model(input logic [N_FEAT-1:0] f);
        int      cnt [N_CLASS];
        int      mx;
        result_t r;
        mx = 0;
        for (int c = 0; c < N_CLASS; c++) begin
            cnt[c] = $countones(f[c*N_TREE +: N_TREE]);
            if (cnt[c] > mx) mx = cnt[c];
        end
        r.cls   = '0;
        r.score = SC_W'(mx);
        for (int c = N_CLASS - 1; c >= 0; c--) begin
            if (cnt[c] == mx) r.cls = CLS_W'(c);
        end
        return r;
    endfunction

    function automatic logic [N_FEAT-1:0] mk(input logic [23:0] votes, input logic [26:0] hi);
        return {hi, votes};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N_FEAT-1:0] f, input bit hold);
        int n;
        n = 0;
        in_feat  = f;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
        exp_q.push_back(model(f));
        step();
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic runEval(input logic [N_FEAT-1:0] f, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            checkOutput("eval_out_valid", 64'(out_valid), 64'd0);
            checkOutput("eval_in_ready", 64'(in_ready), 64'd0);
            checkOutput("eval_busy", 64'(busy), 64'd1);
            checkOutput("eval_class_sel", 64'(tree_class_sel), 64'(k / N_TREE));
            checkOutput("eval_idx_sel", 64'(tree_idx_sel), 64'(k % N_TREE));
            checkOutput("eval_tree_feat", 64'(tree_feat), 64'(f));
            step();
        end
        if (cycles == N_EVAL) checkOutput("latency_out_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic finishResult(input int hold_cycles);
        int      n;
        result_t e;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        checkOutput("result_valid", 64'(out_valid), 64'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checkOutput("out_class", 64'(out_class), 64'(e.cls));
        checkOutput("out_score", 64'(out_score), 64'(e.score));
        for (int h = 0; h < hold_cycles; h++) begin
            step();
            checkOutput("hold_out_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_out_class", 64'(out_class), 64'(e.cls));
            checkOutput("hold_out_score", 64'(out_score), 64'(e.score));
            checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkOutput("post_hs_out_valid", 64'(out_valid), 64'd0);
        checkOutput("post_hs_in_ready", 64'(in_ready), 64'd1);
        checkOutput("post_hs_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N_FEAT-1:0] fa, fb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_feat   = '0;
        step();
        step();
        rst = 1'b0;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_tree_feat", 64'(tree_feat), 64'd0);
        checkOutput("rst_class_sel", 64'(tree_class_sel), 64'd0);
        checkOutput("rst_idx_sel", 64'(tree_idx_sel), 64'd0);
        checkOutput("rst_out_class", 64'(out_class), 64'd0);
        checkOutput("rst_out_score", 64'(out_score), 64'd0);

        $display("[TB] test 1: class 3 wins with three votes");
        fa = mk(24'h007000, 27'h5A5A5A5);
        applyStimulus(fa, 1'b0);
        runEval(fa, N_EVAL);
        finishResult(0);

        $display("[TB] test 2: tie between class 1 and class 4");
        fa = mk(24'h6FA5F3, 27'h1234567);
        applyStimulus(fa, 1'b0);
        runEval(fa, N_EVAL);
        finishResult(0);

        $display("[TB] test 3: all-zero then all-one votes");
        fa = mk(24'h000000, 27'h7FFFFFF);
        applyStimulus(fa, 1'b0);
        runEval(fa, N_EVAL);
        finishResult(0);
        fa = mk(24'hFFFFFF, 27'h0000000);
        applyStimulus(fa, 1'b0);
        runEval(fa, N_EVAL);
        finishResult(0);

        $display("[TB] test 4: output backpressure");
        fa = mk(24'h0310C0, 27'h2AAAAAA);
        applyStimulus(fa, 1'b0);
        runEval(fa, N_EVAL);
        finishResult(10);
        fa = mk(24'hF12345, 27'h3C3C3C3);
        applyStimulus(fa, 1'b0);
        runEval(fa, N_EVAL);
        finishResult(0);

        $display("[TB] test 5: reset during evaluation");
        fa = mk(24'hFFFFFF, 27'h1111111);
        applyStimulus(fa, 1'b0);
        runEval(fa, 10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(exp_q.pop_back());
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_class_sel", 64'(tree_class_sel), 64'd0);
        checkOutput("abort_idx_sel", 64'(tree_idx_sel), 64'd0);
        checkOutput("abort_tree_feat", 64'(tree_feat), 64'd0);
        fa = mk(24'h030100, 27'h0F0F0F0);
        applyStimulus(fa, 1'b0);
        runEval(fa, N_EVAL);
        finishResult(0);

        $display("[TB] test 6: in_valid held during evaluation");
        fa = mk(24'h0F0000, 27'h6666666);
        fb = mk(24'h00000F, 27'h1999999);
        applyStimulus(fa, 1'b1);
        in_feat = fb;
        runEval(fa, N_EVAL);
        finishResult(0);
        exp_q.push_back(model(fb));
        step();
        in_valid = 1'b0;
        runEval(fb, N_EVAL);
        finishResult(0);

        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
